// File: rtl/sector_timer.sv
// Rotational timing generator: bit-cell / sector / revolution counters with strobe, index, mark and ready.
// Optional spin-up revolution counter enabled by `SECTOR_TIMER_SPINUP_EN.
module sector_timer #(
  parameter int unsigned SECTORS            = 16,
  parameter int unsigned SECTOR_BITS        = 3906,
  parameter int unsigned INDEX_WIDTH        = 24,
  parameter int unsigned SECTOR_PULSE_WIDTH = 12,
  parameter int unsigned READY_REVS         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        motor_on,
  output logic        sector_strobe,
  output logic [4:0]  sect,
  output logic        index,
  output logic        sector_mark,
  output logic        ready,
  output logic [11:0] bit_pos
);

  localparam logic [11:0] LAST_BIT  = 12'(SECTOR_BITS - 1);
  localparam logic [4:0]  LAST_SECT = 5'(SECTORS - 1);
  localparam logic [11:0] IDX_W     = 12'(INDEX_WIDTH);
  localparam logic [11:0] MARK_W    = 12'(SECTOR_PULSE_WIDTH);

  // Reject out-of-range configurations at elaboration.
  if (SECTORS < 1 || SECTORS > 32 || SECTOR_BITS < 2 || SECTOR_BITS > 4095 ||
      INDEX_WIDTH < 1 || INDEX_WIDTH > SECTOR_BITS ||
      SECTOR_PULSE_WIDTH < 1 || SECTOR_PULSE_WIDTH > SECTOR_BITS ||
      READY_REVS < 1 || READY_REVS > 255) begin : g_cfg_err
    $error("sector_timer: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  logic [11:0] r_bit_pos;
  logic [4:0]  r_sect;
  logic        r_strobe;
  logic        r_index;
  logic        r_mark;
  logic        r_ready;

  logic        w_end;
  logic        w_wrap;
  logic [11:0] w_bit_nxt;
  logic [4:0]  w_sect_nxt;

  always_comb begin
    w_end      = (r_bit_pos == LAST_BIT);
    w_wrap     = w_end && (r_sect == LAST_SECT);
    w_bit_nxt  = w_end ? 12'd0 : r_bit_pos + 12'd1;
    w_sect_nxt = r_sect;
    if (w_end) w_sect_nxt = w_wrap ? 5'd0 : r_sect + 5'd1;
  end

`ifdef SECTOR_TIMER_SPINUP_EN
  logic [7:0] r_revs;
  logic       w_ready_hit;

  // Wraps counted after the start strobe; ready latches on the READY_REVS-th one.
  assign w_ready_hit = w_wrap && ((9'(r_revs) + 9'd1) >= 9'(READY_REVS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_revs <= 8'd0;
    end else if (r_state != ST_RUN || !motor_on) begin
      r_revs <= 8'd0;
    end else if (w_wrap && r_revs != 8'hFF) begin
      r_revs <= r_revs + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_pos <= 12'd0;
      r_sect    <= 5'd0;
      r_strobe  <= 1'b0;
      r_index   <= 1'b0;
      r_mark    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_pos <= 12'd0;
          r_sect    <= 5'd0;
          if (motor_on) begin
            r_state  <= ST_RUN;
            r_strobe <= 1'b1;
            r_index  <= 1'b1;
            r_mark   <= 1'b1;
`ifdef SECTOR_TIMER_SPINUP_EN
            r_ready  <= 1'b0;
`else
            r_ready  <= 1'b1;
`endif
          end else begin
            r_strobe <= 1'b0;
            r_index  <= 1'b0;
            r_mark   <= 1'b0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          if (!motor_on) begin
            // Stop abandons the partial sector and returns to idle values.
            r_state   <= ST_IDLE;
            r_bit_pos <= 12'd0;
            r_sect    <= 5'd0;
            r_strobe  <= 1'b0;
            r_index   <= 1'b0;
            r_mark    <= 1'b0;
            r_ready   <= 1'b0;
          end else begin
            r_bit_pos <= w_bit_nxt;
            r_sect    <= w_sect_nxt;
            r_strobe  <= w_end;
            r_mark    <= (w_bit_nxt < MARK_W);
            r_index   <= (w_sect_nxt == 5'd0) && (w_bit_nxt < IDX_W);
`ifdef SECTOR_TIMER_SPINUP_EN
            r_ready   <= r_ready | w_ready_hit;
`else
            r_ready   <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

  assign sector_strobe = r_strobe;
  assign sect          = r_sect;
  assign index         = r_index;
  assign sector_mark   = r_mark;
  assign ready         = r_ready;
  assign bit_pos       = r_bit_pos;

endmodule

// File: tb/tb_sector_timer.sv
// Scoreboard bench for sector_timer: directed strobe expectations checked by an independent monitor.
module tb_sector_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        motor_on = 1'b0;
  logic        sector_strobe;
  logic [4:0]  sect;
  logic        index;
  logic        sector_mark;
  logic        ready;
  logic [11:0] bit_pos;

  sector_timer #(
    .SECTORS(4), .SECTOR_BITS(16), .INDEX_WIDTH(3),
    .SECTOR_PULSE_WIDTH(2), .READY_REVS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_on(motor_on),
    .sector_strobe(sector_strobe), .sect(sect), .index(index),
    .sector_mark(sector_mark), .ready(ready), .bit_pos(bit_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [4:0] s;
    logic       rdy;
    logic       idx;
  } exp_t;

  exp_t q[$];
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  int   mark_cnt = 0;
  int   idx_cnt = 0;
  int   bad_idx = 0;
  int   bad_mark = 0;

`ifdef SECTOR_TIMER_SPINUP_EN
  localparam bit SPIN = 1'b1;
`else
  localparam bit SPIN = 1'b0;
`endif

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at_edge=%0d", name, act, exp, edges);
    end
  endtask

  task automatic push(input int at, input int s, input bit rdy);
    exp_t e;
    e.at = at; e.s = 5'(s); e.rdy = rdy; e.idx = (s == 0);
    q.push_back(e);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_strobe"}, int'(sector_strobe), 0);
    chk({name, "_sect"}, int'(sect), 0);
    chk({name, "_index"}, int'(index), 0);
    chk({name, "_mark"}, int'(sector_mark), 0);
    chk({name, "_ready"}, int'(ready), 0);
    chk({name, "_bitpos"}, int'(bit_pos), 0);
  endtask

  // Monitor: every presented strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (sector_mark) mark_cnt++;
    if (index) idx_cnt++;
    if (index && sect != 5'd0) bad_idx++;
    if (sector_mark && bit_pos >= 12'd2) bad_mark++;
    if (sector_strobe) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", edges, -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_cycle", edges, e.at);
        chk("strobe_sect", int'(sect), int'(e.s));
        chk("strobe_ready", int'(ready), int'(e.rdy));
        chk("strobe_index", int'(index), int'(e.idx));
        chk("strobe_mark", int'(sector_mark), 1);
        chk("strobe_bitpos", int'(bit_pos), 0);
      end
    end
  end

  localparam int ST_A[11] = '{1, 17, 33, 49, 65, 81, 97, 113, 129, 145, 161};
  localparam int ST_B[12] = '{1, 17, 33, 49, 65, 81, 97, 113, 129, 145, 161, 177};

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("idle_after_release");

    // Phase A: start, two wraps, stop at bit 9 of sector 2.
    base = edges;
    for (int i = 0; i < 11; i++)
      push(base + ST_A[i], i % 4, SPIN ? (ST_A[i] >= 129) : 1'b1);
    motor_on = 1'b1;
    @(negedge clk);
    chk("first_index", int'(index), 1);
    repeat (2) @(negedge clk);
    chk("index_bit2", int'(index), 1);
    @(negedge clk);
    chk("index_bit3_low", int'(index), 0);
    while (edges < base + 170) @(negedge clk);
    chk("pre_stop_sect", int'(sect), 2);
    chk("pre_stop_bitpos", int'(bit_pos), 9);
    motor_on = 1'b0;
    @(negedge clk);
    chk_idle("stop");

    // Phase B: one-cycle low, restart; fresh spin-up; reset mid-sector-3.
    base = edges;
    for (int i = 0; i < 12; i++)
      push(base + ST_B[i], i % 4, SPIN ? (ST_B[i] >= 129) : 1'b1);
    motor_on = 1'b1;
    while (edges < base + 182) @(negedge clk);
    chk("pre_reset_ready", int'(ready), 1);
    chk("pre_reset_sect", int'(sect), 3);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    @(negedge clk);
    chk_idle("held_reset");

    // Phase C: release with motor_on held high.
    base = edges;
    push(base + 1, 0, !SPIN);
    push(base + 17, 1, !SPIN);
    rst_n = 1'b1;
    while (edges < base + 20) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    chk("mark_cycles", mark_cnt, 50);
    chk("index_cycles", idx_cnt, 21);
    chk("index_outside_s0", bad_idx, 0);
    chk("mark_outside_window", bad_mark, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
